// File: rtl/mmio_router.sv
// mmio_router: one master routed to RAM/UART/timer slaves, one transaction in flight plus a one-entry pending buffer.
// Optional timeout on a hung slave is enabled with `define ROUTER_TIMEOUT_EN.
module mmio_router #(
  parameter logic [31:0] RAM_BASE   = 32'h0000_0000,
  parameter logic [31:0] RAM_SIZE   = 32'h0010_0000,
  parameter logic [31:0] UART_BASE  = 32'h0100_0000,
  parameter logic [31:0] UART_SIZE  = 32'h0000_0010,
  parameter logic [31:0] TIMER_BASE = 32'h0200_0000,
  parameter logic [31:0] TIMER_SIZE = 32'h0000_0010,
  parameter int          TIMEOUT    = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_error,
  output logic        mem_overflow,
  output logic [2:0]  slv_valid,
  output logic        slv_instr,
  output logic [31:0] slv_addr,
  output logic [31:0] slv_wdata,
  output logic [3:0]  slv_wstrb,
  input  logic [95:0] slv_rdata,
  input  logic [2:0]  slv_ready
);
  localparam int NS = 3;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [NS-1:0][31:0] BASE = {TIMER_BASE, UART_BASE, RAM_BASE};
  localparam logic [NS-1:0][31:0] SIZE = {TIMER_SIZE, UART_SIZE, RAM_SIZE};

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("mmio_router: TIMEOUT must be at least 2");
  end

  state_t              state;
  logic [1:0]          sel;
  logic                pend_vld;
  req_t                pend;
  req_t                live;
  req_t                src;
  logic                src_vld;
  logic [NS-1:0]       hit;
  logic [1:0]          hit_idx;
  logic [31:0]         hit_off;
  logic [NS-1:0][31:0] rd_arr;

  assign live    = {mem_instr, mem_addr, mem_wdata, mem_wstrb};
  assign src     = pend_vld ? pend : live;
  assign src_vld = pend_vld | mem_valid;
  assign rd_arr  = slv_rdata;

  // 33-bit compare so a region ending at 2^32 cannot wrap to zero
  for (genvar i = 0; i < NS; i++) begin : g_dec
    assign hit[i] = ({1'b0, src.addr} >= {1'b0, BASE[i]}) &&
                    ({1'b0, src.addr} <  ({1'b0, BASE[i]} + {1'b0, SIZE[i]}));
  end

  always_comb begin
    hit_idx = 2'd0;
    if (hit[0])      hit_idx = 2'd0;
    else if (hit[1]) hit_idx = 2'd1;
    else if (hit[2]) hit_idx = 2'd2;
    hit_off = src.addr - BASE[hit_idx];
  end

`ifdef ROUTER_TIMEOUT_EN
  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      sel          <= '0;
      pend_vld     <= 1'b0;
      pend         <= '0;
      mem_rdata    <= '0;
      mem_ready    <= 1'b0;
      mem_error    <= 1'b0;
      mem_overflow <= 1'b0;
      slv_valid    <= '0;
      slv_instr    <= 1'b0;
      slv_addr     <= '0;
      slv_wdata    <= '0;
      slv_wstrb    <= '0;
`ifdef ROUTER_TIMEOUT_EN
      cnt          <= '0;
`endif
    end else begin
      slv_valid <= '0;
      mem_ready <= 1'b0;
      mem_error <= 1'b0;
      case (state)
        IDLE: if (src_vld) begin
          // pending entry goes first; a simultaneous live request refills the buffer
          if (pend_vld) begin
            pend_vld <= mem_valid;
            if (mem_valid) pend <= live;
          end
          if (|hit) begin
            slv_valid <= NS'(1) << hit_idx;
            slv_addr  <= hit_off;
            slv_instr <= src.instr;
            slv_wdata <= src.wdata;
            slv_wstrb <= src.wstrb;
            sel       <= hit_idx;
            state     <= WAIT;
`ifdef ROUTER_TIMEOUT_EN
            cnt       <= '0;
`endif
          end else begin
            mem_ready <= 1'b1;
            mem_error <= 1'b1;
            mem_rdata <= '0;
            state     <= RESP;
          end
        end
        WAIT: begin
          if (slv_ready[sel]) begin
            mem_ready <= 1'b1;
            mem_rdata <= rd_arr[sel];
            state     <= RESP;
          end
`ifdef ROUTER_TIMEOUT_EN
          else if (cnt == CNT_LAST) begin
            mem_ready <= 1'b1;
            mem_error <= 1'b1;
            mem_rdata <= '0;
            state     <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
`endif
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (state != IDLE && mem_valid) begin
        if (!pend_vld) begin
          pend_vld <= 1'b1;
          pend     <= live;
        end else begin
          mem_overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mmio_router.sv
// Bench for mmio_router: directed vector table, hand-written multi-cycle sequences, and random traffic vs a queue model.
`timescale 1ns/1ps
module tb_mmio_router;
  localparam int TO = 4;
  localparam longint RAM_B = 'h0000_0000, RAM_S = 'h0010_0000;
  localparam longint UART_B = 'h0100_0000, UART_S = 'h10;
  localparam longint TMR_B = 'h0200_0000, TMR_S = 'h10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_valid = 1'b0, mem_instr = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] mem_rdata;
  logic        mem_ready, mem_error, mem_overflow;
  logic [2:0]  slv_valid;
  logic        slv_instr;
  logic [31:0] slv_addr, slv_wdata;
  logic [3:0]  slv_wstrb;
  logic [95:0] slv_rdata;
  logic [2:0]  slv_ready;

  always #5 clk = ~clk;

  mmio_router #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_error(mem_error), .mem_overflow(mem_overflow),
    .slv_valid(slv_valid), .slv_instr(slv_instr), .slv_addr(slv_addr),
    .slv_wdata(slv_wdata), .slv_wstrb(slv_wstrb), .slv_rdata(slv_rdata),
    .slv_ready(slv_ready)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] slave_word(input int i, input logic [31:0] off);
    return 32'h5A00_0000 ^ (32'(i) << 20) ^ (off * 32'h9E37);
  endfunction

  function automatic int idx_of(input logic [2:0] m);
    return m[0] ? 0 : (m[1] ? 1 : 2);
  endfunction

  // spec-level decode: first region with base <= addr < base+size
  function automatic logic [2:0] decode(input logic [31:0] a, output logic [31:0] off);
    longint ua;
    ua  = longint'(a);
    off = '0;
    if (ua >= RAM_B && ua < RAM_B + RAM_S)         begin off = 32'(ua - RAM_B);  return 3'b001; end
    else if (ua >= UART_B && ua < UART_B + UART_S) begin off = 32'(ua - UART_B); return 3'b010; end
    else if (ua >= TMR_B && ua < TMR_B + TMR_S)    begin off = 32'(ua - TMR_B);  return 3'b100; end
    return 3'b000;
  endfunction

  // ---------------- slave responder ----------------
  int          resp_mode = 0;      // 0: answer strobes, 1: hang
  int          lat_min = 1, lat_max = 1;
  bit          noise_en = 1'b0;
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_data = '0;
  int          man_cnt = 0;
  logic [2:0]  man_mask = '0;
  logic [31:0] man_data = '0;

  initial begin : responder
    int          left, man_seen;
    logic [2:0]  act;
    logic [31:0] dat;
    act = '0; left = 0; dat = '0; man_seen = 0;
    slv_ready = '0; slv_rdata = '0;
    forever begin
      @(posedge clk); #1;
      slv_ready = '0;
      slv_rdata = noise_en ? {$urandom(), $urandom(), $urandom()} : {3{32'hBAD0_BAD0}};
      if (!rst) act = '0;
      if (act != 0) begin
        left--;
        if (left <= 0) begin
          slv_ready = act;
          for (int i = 0; i < 3; i++) if (act[i]) slv_rdata[32*i +: 32] = dat;
          act = '0;
        end
      end
      if (rst && slv_valid != 0 && resp_mode == 0) begin
        act  = slv_valid;
        left = int'($urandom_range(lat_max, lat_min));
        dat  = ovr_en ? ovr_data : slave_word(idx_of(slv_valid), slv_addr);
      end
      if (noise_en) slv_ready = slv_ready | (3'($urandom()) & ~act);
      if (man_cnt != man_seen) begin
        man_seen  = man_cnt;
        slv_ready = slv_ready | man_mask;
        for (int i = 0; i < 3; i++) if (man_mask[i]) slv_rdata[32*i +: 32] = man_data;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    mem_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws, input logic ins);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws; mem_instr = ins;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
    logic [31:0] rdata;
    int          lat;
    logic [2:0]  exp_sel;
    logic [31:0] exp_off;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt[12];

  task automatic run_vec(input int id, input vec_t v);
    int ns, nr, tr, ts;
    logic [2:0] gsel; logic [31:0] goff, gwd, grd; logic [3:0] gws; logic gin, gerr;
    ns = 0; nr = 0; tr = -1; ts = -1;
    gsel = '0; goff = '0; gwd = '0; grd = '0; gws = '0; gin = 1'b0; gerr = 1'b0;
    resp_mode = 0; ovr_en = 1'b1; ovr_data = v.rdata; lat_min = v.lat; lat_max = v.lat;
    @(posedge clk); #1;
    drive(v.addr, v.wdata, v.wstrb, v.instr);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) mem_valid = 1'b0;
      if (slv_valid != 0) begin
        ns++; ts = c; gsel = slv_valid; goff = slv_addr; gwd = slv_wdata; gws = slv_wstrb; gin = slv_instr;
      end
      if (mem_ready) begin nr++; tr = c; grd = mem_rdata; gerr = mem_error; end
    end
    chk($sformatf("v%0d_nstrobe", id), ns, (v.exp_sel != 0) ? 1 : 0);
    chk($sformatf("v%0d_sel", id), gsel, v.exp_sel);
    if (v.exp_sel != 0) begin
      chk($sformatf("v%0d_strobe_cyc", id), ts, 1);
      chk($sformatf("v%0d_off", id), goff, v.exp_off);
      chk($sformatf("v%0d_wdata", id), gwd, v.wdata);
      chk($sformatf("v%0d_wstrb", id), gws, v.wstrb);
      chk($sformatf("v%0d_instr", id), gin, v.instr);
    end
    chk($sformatf("v%0d_nready", id), nr, 1);
    chk($sformatf("v%0d_ready_cyc", id), tr, (v.exp_sel != 0) ? 2 + v.lat : 1);
    chk($sformatf("v%0d_err", id), gerr, v.exp_err);
    chk($sformatf("v%0d_rdata", id), grd, v.exp_rdata);
    chk($sformatf("v%0d_rdata_hold", id), mem_rdata, v.exp_rdata);
    ovr_en = 1'b0;
  endtask

  typedef struct { logic [2:0] sel; logic [31:0] off, wdata; logic [3:0] wstrb; logic instr; } iss_t;
  typedef struct { logic err; logic [31:0] rdata; } rsp_t;

  initial begin
    int ns, nr, t_rdy0, t_stb1, t_rdy, t_stb;
    logic [2:0] smask[4]; logic [31:0] soff[4], rdat[2]; logic rerr[2];
    iss_t iq[$]; rsp_t oq[$];
    iss_t ie; rsp_t re;
    logic exp_ovf;

    //           addr          wdata         wstrb ins rdata         lat sel     off          err  exp_rdata
    vt[0]  = '{32'h0200_0008, 32'h0,         4'h0, 0, 32'h0000_002A, 1, 3'b100, 32'h8,       0, 32'h0000_002A};
    vt[1]  = '{32'h0200_0004, 32'hDEAD_BEEF, 4'hF, 0, 32'h0000_0011, 1, 3'b100, 32'h4,       0, 32'h0000_0011};
    vt[2]  = '{32'h0300_0000, 32'h0,         4'h0, 0, 32'h1111_1111, 1, 3'b000, 32'h0,       1, 32'h0};
    vt[3]  = '{32'h0000_0000, 32'h0,         4'h0, 1, 32'h1234_5678, 2, 3'b001, 32'h0,       0, 32'h1234_5678};
    vt[4]  = '{32'h000F_FFFC, 32'h0A0B_0C0D, 4'h1, 0, 32'h8765_4321, 3, 3'b001, 32'hF_FFFC,  0, 32'h8765_4321};
    vt[5]  = '{32'h0010_0000, 32'h0,         4'h0, 0, 32'h2222_2222, 1, 3'b000, 32'h0,       1, 32'h0};
    vt[6]  = '{32'h0100_000C, 32'hCAFE_0001, 4'h3, 0, 32'h0000_0077, 1, 3'b010, 32'hC,       0, 32'h0000_0077};
    vt[7]  = '{32'h0100_0010, 32'h0,         4'h0, 0, 32'h3333_3333, 1, 3'b000, 32'h0,       1, 32'h0};
    vt[8]  = '{32'h0200_0000, 32'h0,         4'h0, 1, 32'h0BAD_F00D, 2, 3'b100, 32'h0,       0, 32'h0BAD_F00D};
    vt[9]  = '{32'h0200_0010, 32'h0,         4'h0, 0, 32'h4444_4444, 1, 3'b000, 32'h0,       1, 32'h0};
    vt[10] = '{32'hFFFF_FFFC, 32'h0,         4'hF, 0, 32'h5555_5555, 1, 3'b000, 32'h0,       1, 32'h0};
    vt[11] = '{32'h00FF_FFFF, 32'h0,         4'h0, 0, 32'h6666_6666, 1, 3'b000, 32'h0,       1, 32'h0};

    // reset values
    #2;
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_mem_error", mem_error, 0);
    chk("rst_mem_ovf", mem_overflow, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_slv_valid", slv_valid, 0);
    chk("rst_slv_addr", slv_addr, 0);
    do_reset();

    for (int i = 0; i < 12; i++) run_vec(i, vt[i]);
    chk("vec_no_ovf", mem_overflow, 0);

    // back-to-back: second request pends, third is dropped
    do_reset();
    resp_mode = 0; noise_en = 1'b0; lat_min = 3; lat_max = 3;
    ns = 0; nr = 0; t_rdy0 = -1; t_stb1 = -1;
    for (int c = 0; c <= 30; c++) begin
      @(posedge clk); #1;
      mem_valid = 1'b0;
      if (slv_valid != 0) begin
        if (ns < 4) begin smask[ns] = slv_valid; soff[ns] = slv_addr; end
        if (ns == 1) t_stb1 = c;
        ns++;
      end
      if (mem_ready) begin
        if (nr < 2) begin rdat[nr] = mem_rdata; rerr[nr] = mem_error; end
        if (nr == 0) t_rdy0 = c;
        nr++;
      end
      if (c == 3) chk("b2b_ovf_before", mem_overflow, 0);
      if (c == 4) chk("b2b_ovf_set", mem_overflow, 1);
      if (c == 0) drive(32'h0000_0100, 32'h0, 4'h0, 1'b0);
      if (c == 2) drive(32'h0100_0004, 32'h0, 4'h0, 1'b0);
      if (c == 3) drive(32'h0200_0000, 32'h0, 4'h0, 1'b0);
    end
    chk("b2b_nstrobe", ns, 2);
    chk("b2b_nready", nr, 2);
    if (ns >= 2 && nr >= 2) begin
      chk("b2b_s0_sel", smask[0], 3'b001);
      chk("b2b_s0_off", soff[0], 32'h100);
      chk("b2b_s1_sel", smask[1], 3'b010);
      chk("b2b_s1_off", soff[1], 32'h4);
      chk("b2b_r0_data", rdat[0], slave_word(0, 32'h100));
      chk("b2b_r0_err", rerr[0], 0);
      chk("b2b_r1_data", rdat[1], slave_word(1, 32'h4));
      chk("b2b_r1_err", rerr[1], 0);
      chk("b2b_order", (t_stb1 > t_rdy0) ? 1 : 0, 1);
    end
    chk("b2b_ovf_sticky", mem_overflow, 1);

    // hung UART
    do_reset();
    resp_mode = 1;
    @(posedge clk); #1;
    drive(32'h0100_0000, 32'h0, 4'h0, 1'b0);
    nr = 0; t_stb = -1; t_rdy = -1;
    for (int c = 1; c <= 1000; c++) begin
      @(posedge clk); #1;
      mem_valid = 1'b0;
      if (slv_valid != 0 && t_stb < 0) t_stb = c;
      if (mem_ready) begin
        if (nr == 0) begin t_rdy = c; rerr[0] = mem_error; rdat[0] = mem_rdata; end
        nr++;
      end
    end
    chk("hang_strobe_cyc", t_stb, 1);
`ifdef ROUTER_TIMEOUT_EN
    chk("to_nready", nr, 1);
    chk("to_wait_cycles", t_rdy - t_stb, 4);
    if (nr > 0) begin
      chk("to_err", rerr[0], 1);
      chk("to_rdata", rdat[0], 0);
    end
`else
    chk("hang_no_ready", nr, 0);
`endif

    // reset during WAIT, late ready afterwards
    do_reset();
    resp_mode = 1;
    @(posedge clk); #1;
    drive(32'h0200_0008, 32'h1234_0000, 4'h0, 1'b1);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    chk("rw_strobe", slv_valid, 3'b100);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rw_valid0", slv_valid, 0);
    chk("rw_ready0", mem_ready, 0);
    chk("rw_err0", mem_error, 0);
    chk("rw_rdata0", mem_rdata, 0);
    chk("rw_addr0", slv_addr, 0);
    chk("rw_instr0", slv_instr, 0);
    chk("rw_ovf0", mem_overflow, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    man_mask = 3'b100; man_data = 32'h99; man_cnt++;
    nr = 0; ns = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (mem_ready) nr++;
      if (slv_valid != 0) ns++;
    end
    chk("rw_no_ready", nr, 0);
    chk("rw_no_strobe", ns, 0);
    run_vec(100, vt[0]);

    // random traffic against the queue model
    do_reset();
    resp_mode = 0; noise_en = 1'b1; lat_min = 1; lat_max = 3;
    exp_ovf = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      int s, cat;
      logic [31:0] a, off;
      logic [2:0] m;
      @(posedge clk); #1;
      s = oq.size();
      if (slv_valid != 0) begin
        if (iq.size() == 0) chk("rnd_unexp_strobe", slv_valid, 0);
        else begin
          ie = iq.pop_front();
          chk("rnd_sel", slv_valid, ie.sel);
          chk("rnd_off", slv_addr, ie.off);
          chk("rnd_wdata", slv_wdata, ie.wdata);
          chk("rnd_wstrb", slv_wstrb, ie.wstrb);
          chk("rnd_instr", slv_instr, ie.instr);
        end
      end
      if (mem_ready) begin
        if (oq.size() == 0) chk("rnd_unexp_ready", mem_ready, 0);
        else begin
          re = oq.pop_front();
          chk("rnd_err", mem_error, re.err);
          chk("rnd_rdata", mem_rdata, re.rdata);
        end
      end
      chk("rnd_ovf", mem_overflow, exp_ovf);
      mem_valid = 1'b0;
      if (t < 2900 && $urandom_range(2, 0) == 0) begin
        cat = int'($urandom_range(4, 0));
        case (cat)
          0: a = 32'($urandom_range(32'h000F_FFFF, 0)) & 32'hFFFF_FFFC;
          1: a = 32'h0100_0000 + 32'($urandom_range(15, 0));
          2: a = 32'h0200_0000 + 4 * 32'($urandom_range(3, 0));
          3: a = ($urandom_range(1, 0) == 0) ? 32'h0100_0010 : 32'h0010_0000;
          default: a = $urandom();
        endcase
        drive(a, $urandom(), 4'($urandom()), 1'($urandom()));
        if (s >= 2) exp_ovf = 1'b1;
        else begin
          m = decode(a, off);
          if (m != 0) begin
            iq.push_back('{m, off, mem_wdata, mem_wstrb, mem_instr});
            oq.push_back('{1'b0, slave_word(idx_of(m), off)});
          end else begin
            oq.push_back('{1'b1, 32'h0});
          end
        end
      end
    end
    chk("rnd_drain_resp", oq.size(), 0);
    chk("rnd_drain_issue", iq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
